ram_arbiter: RTL and testbench



---
 rtl/ram_arbiter_if.sv | 26 ++
 rtl/ram_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_ram_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_arbiter_if.sv
// Requester-side bundle for one port of the program/sprite RAM arbiter.
// The requester drives the access fields and the arbiter answers with a grant.
// Read data comes back as a tagged valid pulse.
interface ram_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
);
    logic              req;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              lock;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, wr, addr, wdata, lock,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, wr, addr, wdata, lock,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/ram_arbiter.sv
// Arbiter for the shared 4 KiB x 8 program/sprite RAM.
// Three requesters share the RAM: the CPU (0), the blitter (1) and the ROM loader (2).
// Arbitration is round-robin and grants one access per cycle.
// A port may lock the bus for a burst; the lock has a bounded length.
// Read results return through a tagged pipeline that tells each port when rdata is its own.
module ram_arbiter #(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 8,
    parameter int RD_LATENCY = 1,
    parameter int LOCK_MAX   = 64
) (
    input  logic              clk,
    input  logic              res,
    ram_arbiter_if.slave      cpu,
    ram_arbiter_if.slave      blit,
    ram_arbiter_if.slave      ldr,
    output logic              ram_en,
    output logic              ram_wr,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_in,
    input  logic [DATA_W-1:0] ram_out
);

    localparam int         CNT_W     = $clog2(LOCK_MAX) + 1;
    localparam logic [1:0] TAG_NONE  = 2'd3;
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_MAX - 1);

    logic [2:0]        w_req;
    logic [2:0]        w_wr;
    logic [2:0]        w_lock;
    logic [ADDR_W-1:0] w_addr [3];
    logic [DATA_W-1:0] w_wdata [3];

    logic [2:0]        w_elig;
    logic [2:0]        w_gnt;
    logic [1:0]        w_gntIdx;
    logic [2:0]        w_cand;
    logic              w_xfer;
    logic              w_selWr;
    logic              w_selLock;
    logic [ADDR_W-1:0] w_selAddr;
    logic [DATA_W-1:0] w_selWdata;
    logic [CNT_W-1:0]  w_cntNext;
    logic [2:0]        w_retDec;

    logic [1:0]        r_rrPtr;
    logic              r_ownerValid;
    logic [1:0]        r_owner;
    logic [CNT_W-1:0]  r_lockCnt;
    logic              r_exclValid;
    logic [1:0]        r_exclIdx;
    logic [1:0]        r_tagPipe [RD_LATENCY];
    logic [2:0]        r_rvalid;
    logic              r_ramEn;
    logic              r_ramWr;
    logic [ADDR_W-1:0] r_ramAddr;
    logic [DATA_W-1:0] r_ramIn;

    assign w_req      = {ldr.req,  blit.req,  cpu.req};
    assign w_wr       = {ldr.wr,   blit.wr,   cpu.wr};
    assign w_lock     = {ldr.lock, blit.lock, cpu.lock};
    assign w_addr[0]  = cpu.addr;
    assign w_addr[1]  = blit.addr;
    assign w_addr[2]  = ldr.addr;
    assign w_wdata[0] = cpu.wdata;
    assign w_wdata[1] = blit.wdata;
    assign w_wdata[2] = ldr.wdata;

    // Drop a port that just timed out of its lock from the one arbitration cycle after the timeout.
    // Limiting this to one cycle keeps a lone requester from starving.
    always_comb begin
        w_elig = w_req;
        if (r_exclValid) begin
            w_elig[r_exclIdx] = 1'b0;
        end
    end

    // Pick the winner: only the lock owner while a lock is held, otherwise the first eligible port from rr_ptr.
    // The loop walks from lowest to highest priority so the highest-priority hit is written last.
    always_comb begin
        w_gnt    = 3'b000;
        w_gntIdx = 2'd0;
        w_cand   = 3'd0;
        if (!res) begin
            if (r_ownerValid) begin
                if (w_req[r_owner]) begin
                    w_gnt[r_owner] = 1'b1;
                    w_gntIdx       = r_owner;
                end
            end else begin
                for (int k = 2; k >= 0; k--) begin
                    w_cand = {1'b0, r_rrPtr} + 3'(k);
                    if (w_cand >= 3'd3) begin
                        w_cand = w_cand - 3'd3;
                    end
                    if (w_elig[w_cand[1:0]]) begin
                        w_gnt              = 3'b000;
                        w_gnt[w_cand[1:0]] = 1'b1;
                        w_gntIdx           = w_cand[1:0];
                    end
                end
            end
        end
    end

    assign w_xfer     = |w_gnt;
    assign w_selWr    = w_wr[w_gntIdx];
    assign w_selLock  = w_lock[w_gntIdx];
    assign w_selAddr  = w_addr[w_gntIdx];
    assign w_selWdata = w_wdata[w_gntIdx];
    assign w_cntNext  = r_lockCnt + 1'b1;

    // Advance the round-robin pointer and track lock ownership, release and forced timeout.
    always_ff @(posedge clk) begin
        if (res) begin
            r_rrPtr      <= 2'd0;
            r_ownerValid <= 1'b0;
            r_owner      <= 2'd0;
            r_lockCnt    <= '0;
            r_exclValid  <= 1'b0;
            r_exclIdx    <= 2'd0;
        end else begin
            r_exclValid <= 1'b0;
            if (w_xfer) begin
                r_rrPtr <= (w_gntIdx == 2'd2) ? 2'd0 : w_gntIdx + 2'd1;
            end
            if (r_ownerValid) begin
                if (w_cntNext == LOCK_LAST) begin
                    r_ownerValid <= 1'b0;
                    r_lockCnt    <= '0;
                    r_exclValid  <= 1'b1;
                    r_exclIdx    <= r_owner;
                end else if (!w_lock[r_owner]) begin
                    r_ownerValid <= 1'b0;
                    r_lockCnt    <= '0;
                end else begin
                    r_lockCnt <= w_cntNext;
                end
            end else if (w_xfer && w_selLock) begin
                r_ownerValid <= 1'b1;
                r_owner      <= w_gntIdx;
                r_lockCnt    <= '0;
            end
        end
    end

    // Register the granted access onto the RAM pins.
    // Address and data hold their values when no transfer happens.
    always_ff @(posedge clk) begin
        if (res) begin
            r_ramEn   <= 1'b0;
            r_ramWr   <= 1'b0;
            r_ramAddr <= '0;
            r_ramIn   <= '0;
        end else if (w_xfer) begin
            r_ramEn   <= 1'b1;
            r_ramWr   <= w_selWr;
            r_ramAddr <= w_selAddr;
            r_ramIn   <= w_selWdata;
        end else begin
            r_ramEn <= 1'b0;
            r_ramWr <= 1'b0;
        end
    end

    // Decode the tag leaving the pipeline into a one-hot per-port return strobe.
    always_comb begin
        w_retDec = 3'b000;
        if (r_tagPipe[RD_LATENCY-1] != TAG_NONE) begin
            w_retDec[r_tagPipe[RD_LATENCY-1]] = 1'b1;
        end
    end

    // Shift read tags along with the RAM latency.
    // Writes and idle cycles push an empty slot.
    always_ff @(posedge clk) begin
        if (res) begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                r_tagPipe[i] <= TAG_NONE;
            end
            r_rvalid <= 3'b000;
        end else begin
            r_tagPipe[0] <= (w_xfer && !w_selWr) ? w_gntIdx : TAG_NONE;
            for (int i = 1; i < RD_LATENCY; i++) begin
                r_tagPipe[i] <= r_tagPipe[i-1];
            end
            r_rvalid <= w_retDec;
        end
    end

    assign ram_en   = r_ramEn;
    assign ram_wr   = r_ramWr;
    assign ram_addr = r_ramAddr;
    assign ram_in   = r_ramIn;

    assign cpu.gnt     = w_gnt[0];
    assign blit.gnt    = w_gnt[1];
    assign ldr.gnt     = w_gnt[2];
    assign cpu.rvalid  = r_rvalid[0];
    assign blit.rvalid = r_rvalid[1];
    assign ldr.rvalid  = r_rvalid[2];
    assign cpu.rdata   = ram_out;
    assign blit.rdata  = ram_out;
    assign ldr.rdata   = ram_out;

endmodule

// File: tb/tb_ram_arbiter.sv
// Testbench for ram_arbiter with a behavioural write-first RAM of one-cycle latency.
// Each cycle's expected grant is stated explicitly, and the RAM pins are checked against it.
// Each expected read return goes into a scoreboard and is compared when it falls due.
module tb_ram_arbiter;

    localparam int ADDR_W     = 12;
    localparam int DATA_W     = 8;
    localparam int RD_LATENCY = 1;
    localparam int LOCK_MAX   = 4;

    typedef struct {
        int              due;
        logic [1:0]      tag;
        logic [DATA_W-1:0] data;
    } sbEntry_t;

    logic              clk = 1'b0;
    logic              res;
    logic              ramEn;
    logic              ramWr;
    logic [ADDR_W-1:0] ramAddr;
    logic [DATA_W-1:0] ramIn;
    logic [DATA_W-1:0] ramOut;

    logic [2:0]        tReq;
    logic [2:0]        tWr;
    logic [2:0]        tLock;
    logic [ADDR_W-1:0] tAddr [3];
    logic [DATA_W-1:0] tWdata [3];

    logic [DATA_W-1:0] shadow [4096];
    sbEntry_t          sbQueue [$];

    logic              expRamEn;
    logic              expRamWr;
    logic [ADDR_W-1:0] expRamAddr;
    logic [DATA_W-1:0] expRamIn;

    int   checkCount = 0;
    int   failCount  = 0;
    int   cycleCnt   = 0;
    logic monitorOn  = 1'b0;

    logic [2:0]        monExpVld;
    logic [DATA_W-1:0] monExpData;
    logic [DATA_W-1:0] monRdata;
    sbEntry_t          monEntry;

    ram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) cpuIf ();
    ram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) blitIf ();
    ram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) ldrIf ();

    assign cpuIf.req    = tReq[0];
    assign cpuIf.wr     = tWr[0];
    assign cpuIf.lock   = tLock[0];
    assign cpuIf.addr   = tAddr[0];
    assign cpuIf.wdata  = tWdata[0];
    assign blitIf.req   = tReq[1];
    assign blitIf.wr    = tWr[1];
    assign blitIf.lock  = tLock[1];
    assign blitIf.addr  = tAddr[1];
    assign blitIf.wdata = tWdata[1];
    assign ldrIf.req    = tReq[2];
    assign ldrIf.wr     = tWr[2];
    assign ldrIf.lock   = tLock[2];
    assign ldrIf.addr   = tAddr[2];
    assign ldrIf.wdata  = tWdata[2];

    ram_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .RD_LATENCY (RD_LATENCY),
        .LOCK_MAX   (LOCK_MAX)
    ) dut (
        .clk      (clk),
        .res      (res),
        .cpu      (cpuIf),
        .blit     (blitIf),
        .ldr      (ldrIf),
        .ram_en   (ramEn),
        .ram_wr   (ramWr),
        .ram_addr (ramAddr),
        .ram_in   (ramIn),
        .ram_out  (ramOut)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    function automatic logic [DATA_W-1:0] preloadVal(input logic [ADDR_W-1:0] a);
        return (a == 12'h180) ? 8'h12 : (a[7:0] ^ 8'h5A);
    endfunction

    // Write-first synchronous RAM model with preloaded contents
    initial begin
        logic [DATA_W-1:0] mem [4096];
        for (int a = 0; a < 4096; a++) begin
            mem[a] = preloadVal(12'(a));
        end
        ramOut = '0;
        forever begin
            @(posedge clk);
            if (ramEn) begin
                if (ramWr) begin
                    mem[ramAddr] <= ramIn;
                    ramOut       <= ramIn;
                end else begin
                    ramOut <= mem[ramAddr];
                end
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", tag, cycleCnt, actual, expected);
        end
    endtask

    task automatic setPort(input int idx, input logic req, input logic wr, input logic [ADDR_W-1:0] addr,
                           input logic [DATA_W-1:0] wdata, input logic lock);
        tReq[idx]   = req;
        tWr[idx]    = wr;
        tAddr[idx]  = addr;
        tWdata[idx] = wdata;
        tLock[idx]  = lock;
    endtask

    // One cycle: check grants and RAM pins, record the expected access, advance to just after the edge
    task automatic applyStimulus(input logic [2:0] expGnt);
        int       idx;
        sbEntry_t entry;
        @(negedge clk);
        checkOutput("gnt", 32'({ldrIf.gnt, blitIf.gnt, cpuIf.gnt}), 32'(expGnt));
        checkOutput("ram_en", 32'(ramEn), 32'(expRamEn));
        checkOutput("ram_wr", 32'(ramWr), 32'(expRamWr));
        checkOutput("ram_addr", 32'(ramAddr), 32'(expRamAddr));
        checkOutput("ram_in", 32'(ramIn), 32'(expRamIn));
        if (expGnt != 3'b000) begin
            idx        = expGnt[0] ? 0 : (expGnt[1] ? 1 : 2);
            expRamEn   = 1'b1;
            expRamWr   = tWr[idx];
            expRamAddr = tAddr[idx];
            expRamIn   = tWdata[idx];
            if (tWr[idx]) begin
                shadow[tAddr[idx]] = tWdata[idx];
            end else begin
                entry.due  = cycleCnt + 1 + RD_LATENCY;
                entry.tag  = 2'(idx);
                entry.data = shadow[tAddr[idx]];
                sbQueue.push_back(entry);
            end
        end else begin
            expRamEn = 1'b0;
            expRamWr = 1'b0;
        end
        @(posedge clk);
        if (res) begin
            expRamEn   = 1'b0;
            expRamWr   = 1'b0;
            expRamAddr = '0;
            expRamIn   = '0;
            sbQueue.delete();
        end
        #1;
    endtask

    task automatic drain(input int n);
        tReq  = 3'b000;
        tLock = 3'b000;
        repeat (n) applyStimulus(3'b000);
    endtask

    task automatic resetDut();
        tReq  = 3'b000;
        tLock = 3'b000;
        res   = 1'b1;
        applyStimulus(3'b000);
        res   = 1'b0;
    endtask

    // Read-return monitor: every cycle the rvalid vector must equal what the scoreboard says is due
    always @(negedge clk) begin
        if (monitorOn) begin
            monExpVld  = 3'b000;
            monExpData = '0;
            if (sbQueue.size() > 0 && sbQueue[0].due == cycleCnt) begin
                monEntry             = sbQueue.pop_front();
                monExpVld[monEntry.tag] = 1'b1;
                monExpData           = monEntry.data;
            end
            checkOutput("rvalid", 32'({ldrIf.rvalid, blitIf.rvalid, cpuIf.rvalid}), 32'(monExpVld));
            if (monExpVld != 3'b000) begin
                monRdata = monExpVld[0] ? cpuIf.rdata : (monExpVld[1] ? blitIf.rdata : ldrIf.rdata);
                checkOutput("rdata", 32'(monRdata), 32'(monExpData));
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        res   = 1'b1;
        tReq  = 3'b000;
        tWr   = 3'b000;
        tLock = 3'b000;
        for (int i = 0; i < 3; i++) begin
            tAddr[i]  = '0;
            tWdata[i] = '0;
        end
        for (int a = 0; a < 4096; a++) begin
            shadow[a] = preloadVal(12'(a));
        end
        expRamEn   = 1'b0;
        expRamWr   = 1'b0;
        expRamAddr = '0;
        expRamIn   = '0;

        $display("[TB] reset state");
        repeat (3) @(posedge clk);
        #1;
        monitorOn = 1'b1;
        setPort(0, 1'b1, 1'b0, 12'h005, 8'h00, 1'b0);
        applyStimulus(3'b000);
        setPort(0, 1'b0, 1'b0, 12'h000, 8'h00, 1'b0);
        res = 1'b0;

        $display("[TB] single cpu read");
        setPort(0, 1'b1, 1'b0, 12'h180, 8'h00, 1'b0);
        applyStimulus(3'b001);
        setPort(0, 1'b0, 1'b0, 12'h180, 8'h00, 1'b0);
        drain(3);

        $display("[TB] three-way contention");
        resetDut();
        setPort(0, 1'b1, 1'b0, 12'h010, 8'h00, 1'b0);
        setPort(1, 1'b1, 1'b0, 12'h020, 8'h00, 1'b0);
        setPort(2, 1'b1, 1'b0, 12'h030, 8'h00, 1'b0);
        for (int r = 0; r < 2; r++) begin
            applyStimulus(3'b001);
            applyStimulus(3'b010);
            applyStimulus(3'b100);
        end
        drain(3);

        $display("[TB] locked burst");
        resetDut();
        setPort(1, 1'b1, 1'b0, 12'h210, 8'h00, 1'b0);
        for (int i = 0; i < 4; i++) begin
            setPort(0, 1'b1, 1'b1, 12'h200 + 12'(i), 8'hC0 + 8'(i), (i < 3));
            applyStimulus(3'b001);
        end
        setPort(0, 1'b0, 1'b0, 12'h203, 8'h00, 1'b0);
        applyStimulus(3'b010);
        drain(3);
        for (int i = 0; i < 4; i++) begin
            setPort(0, 1'b1, 1'b0, 12'h200 + 12'(i), 8'h00, 1'b0);
            applyStimulus(3'b001);
        end
        drain(3);

        $display("[TB] lock timeout");
        resetDut();
        setPort(0, 1'b1, 1'b0, 12'h040, 8'h00, 1'b1);
        setPort(1, 1'b1, 1'b0, 12'h050, 8'h00, 1'b0);
        repeat (4) applyStimulus(3'b001);
        applyStimulus(3'b010);
        applyStimulus(3'b001);
        drain(3);

        $display("[TB] reset mid-read");
        resetDut();
        setPort(2, 1'b1, 1'b0, 12'h060, 8'h00, 1'b0);
        applyStimulus(3'b100);
        setPort(2, 1'b0, 1'b0, 12'h060, 8'h00, 1'b0);
        setPort(0, 1'b1, 1'b0, 12'h070, 8'h00, 1'b0);
        res = 1'b1;
        applyStimulus(3'b000);
        res = 1'b0;
        setPort(0, 1'b0, 1'b0, 12'h070, 8'h00, 1'b0);
        drain(3);

        $display("[TB] write then read same address");
        resetDut();
        setPort(0, 1'b1, 1'b1, 12'h300, 8'hAB, 1'b0);
        applyStimulus(3'b001);
        setPort(0, 1'b0, 1'b0, 12'h300, 8'h00, 1'b0);
        setPort(1, 1'b1, 1'b0, 12'h300, 8'h00, 1'b0);
        applyStimulus(3'b010);
        drain(3);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
